// File: rtl/window_ctrl.sv
// Sequencer for the 5x5 window line buffer: tracks frame/line/pixel position and qualifies kernel output.
// Optional WIDTH_CHECK_EN adds a sticky width_err flag that also suppresses kernel_valid.
module window_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int MAX_WIDTH = 1920,
  parameter int KSIZE     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic              rx_hs,
  input  logic              rx_vs,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_we,
  output logic [ADDR_W-1:0] line_width,
  output logic [11:0]       row_cnt,
  output logic              kernel_valid,
  output logic [1:0]        state,
`ifdef WIDTH_CHECK_EN
  output logic              width_err,
`endif
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    FILL   = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_COL   = ADDR_W'(MAX_WIDTH);
  localparam logic [ADDR_W-1:0] KMIN_COL  = ADDR_W'(KSIZE - 1);
  localparam logic [11:0]       FILL_ROWS = 12'(KSIZE - 2);

  state_t            cur_state, next_state;
  logic              dv_q, hs_q, vs_q, dv_p, hs_p;
  logic [ADDR_W-1:0] col;
  logic              werr_q;
  logic              active, col_full, line_end, clear_frame;

  assign active      = (cur_state == FILL) || (cur_state == RUN);
  assign col_full    = (col >= MAX_COL);
  // Either a dv falling edge or an hsync rising edge closes the line; col>0 makes it fire once.
  assign line_end    = active && !vs_q && ((dv_p && !dv_q) || (hs_q && !hs_p)) && (col != '0);
  assign clear_frame = (cur_state == VBLANK) || (active && vs_q);

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:    if (vs_q) next_state = VBLANK;
      VBLANK:  if (!vs_q) next_state = FILL;
      FILL: begin
        if (vs_q) next_state = VBLANK;
        else if (line_end && (row_cnt == FILL_ROWS)) next_state = RUN;
      end
      RUN:     if (vs_q) next_state = VBLANK;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    buf_addr     = col_full ? (MAX_COL - 1'b1) : col;
    buf_we       = dv_q && active && !col_full;
    kernel_valid = dv_q && (cur_state == RUN) && !vs_q && !col_full && (col >= KMIN_COL);
`ifdef WIDTH_CHECK_EN
    if (werr_q) kernel_valid = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state  <= IDLE;
      dv_q       <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      dv_p       <= 1'b0;
      hs_p       <= 1'b0;
      col        <= '0;
      line_width <= '0;
      row_cnt    <= '0;
      overflow   <= 1'b0;
      werr_q     <= 1'b0;
    end else begin
      cur_state <= next_state;
      dv_q      <= rx_dv;
      hs_q      <= rx_hs;
      vs_q      <= rx_vs;
      dv_p      <= dv_q;
      hs_p      <= hs_q;
      // Vsync beats a coincident line end, so the frame restarts with row_cnt at zero.
      if (clear_frame) begin
        col      <= '0;
        row_cnt  <= '0;
        overflow <= 1'b0;
        werr_q   <= 1'b0;
      end else if (line_end) begin
        if ((row_cnt != '0) && (col != line_width)) werr_q <= 1'b1;
        line_width <= col;
        if (row_cnt != 12'hFFF) row_cnt <= row_cnt + 12'd1;
        col <= '0;
      end else if (active && dv_q) begin
        if (col_full) overflow <= 1'b1;
        else col <= col + 1'b1;
      end
    end
  end

  assign state = cur_state;

`ifdef WIDTH_CHECK_EN
  assign width_err = werr_q;
`endif

endmodule

// File: tb/tb_window_ctrl.sv
// Randomized bench for window_ctrl: two instances (default and MAX_WIDTH=8) checked against a frame-level model.
// Expectations for width_err follow WIDTH_CHECK_EN when it is defined.
module tb_window_ctrl;

  localparam int SMALL_W = 8;
  localparam int BIG_W   = 1920;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_dv = 1'b0, rx_hs = 1'b0, rx_vs = 1'b0;

  logic [10:0] a_addr, a_lw, b_addr, b_lw;
  logic [11:0] a_row, b_row;
  logic [1:0]  a_state, b_state;
  logic        a_we, a_kv, a_ovf, b_we, b_kv, b_ovf;
  logic        a_werr, b_werr;

  int vectors = 0;
  int miscompares = 0;
  int kv_cnt_a, kv_cnt_b, we_cnt_a, we_cnt_b;

  typedef struct {
    bit synced;
    bit blank;
    bit dv_q, hs_q, vs_q, dv_p, hs_p;
    int col, row, lw;
    bit ovf, werr;
  } model_t;

  model_t ma, mb;

  always #5 clk = ~clk;

  window_ctrl dut_a (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
    .buf_addr(a_addr), .buf_we(a_we), .line_width(a_lw), .row_cnt(a_row),
    .kernel_valid(a_kv), .state(a_state),
`ifdef WIDTH_CHECK_EN
    .width_err(a_werr),
`endif
    .overflow(a_ovf)
  );

  window_ctrl #(.MAX_WIDTH(SMALL_W)) dut_b (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
    .buf_addr(b_addr), .buf_we(b_we), .line_width(b_lw), .row_cnt(b_row),
    .kernel_valid(b_kv), .state(b_state),
`ifdef WIDTH_CHECK_EN
    .width_err(b_werr),
`endif
    .overflow(b_ovf)
  );

`ifndef WIDTH_CHECK_EN
  assign a_werr = 1'b0;
  assign b_werr = 1'b0;
`endif

  function automatic model_t model_reset();
    model_t m;
    m = '{default: 0};
    return m;
  endfunction

  // One clock of the frame model: edges come from the previously registered inputs.
  function automatic model_t model_step(model_t m, int maxw, bit dv, bit hs, bit vs);
    model_t n;
    bit ends;
    n = m;
    n.dv_q = dv;
    n.hs_q = hs;
    n.vs_q = vs;
    n.dv_p = m.dv_q;
    n.hs_p = m.hs_q;
    if (!m.synced) begin
      if (m.vs_q) begin
        n.synced = 1;
        n.blank  = 1;
      end
    end else if (m.blank || m.vs_q) begin
      n.blank = m.vs_q;
      n.col = 0;
      n.row = 0;
      n.ovf = 0;
      n.werr = 0;
    end else begin
      ends = ((m.dv_p && !m.dv_q) || (m.hs_q && !m.hs_p)) && (m.col > 0);
      if (ends) begin
`ifdef WIDTH_CHECK_EN
        if (m.row >= 1 && m.col != m.lw) n.werr = 1;
`endif
        n.lw  = m.col;
        n.row = (m.row < 4095) ? m.row + 1 : 4095;
        n.col = 0;
      end else if (m.dv_q) begin
        if (m.col < maxw) n.col = m.col + 1;
        else n.ovf = 1;
      end
    end
    return n;
  endfunction

  function automatic int exp_state(model_t m);
    if (!m.synced) return 0;
    if (m.blank) return 1;
    if (m.row >= 4) return 3;
    return 2;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkModel(input string who, input model_t m, input int maxw,
                            input int addr, input int we, input int lw, input int row,
                            input int kv, input int st, input int ovf, input int werr);
    bit run_ok;
    run_ok = (exp_state(m) == 3) && !m.vs_q && m.dv_q && (m.col >= 4) && (m.col < maxw) && !m.werr;
    checkOutput({who, ".state"}, st, exp_state(m));
    checkOutput({who, ".buf_addr"}, addr, (m.col < maxw) ? m.col : maxw - 1);
    checkOutput({who, ".buf_we"}, we, int'(m.dv_q && m.synced && !m.blank && (m.col < maxw)));
    checkOutput({who, ".line_width"}, lw, m.lw);
    checkOutput({who, ".row_cnt"}, row, m.row);
    checkOutput({who, ".kernel_valid"}, kv, int'(run_ok));
    checkOutput({who, ".overflow"}, ovf, int'(m.ovf));
    checkOutput({who, ".width_err"}, werr, int'(m.werr));
  endtask

  task automatic applyStimulus(input bit rst_n, input bit dv, input bit hs, input bit vs);
    @(negedge clk);
    rst   = rst_n;
    rx_dv = dv;
    rx_hs = hs;
    rx_vs = vs;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      ma = model_reset();
      mb = model_reset();
    end else begin
      ma = model_step(ma, BIG_W, dv, hs, vs);
      mb = model_step(mb, SMALL_W, dv, hs, vs);
    end
    checkModel("a", ma, BIG_W, int'(a_addr), int'(a_we), int'(a_lw), int'(a_row),
               int'(a_kv), int'(a_state), int'(a_ovf), int'(a_werr));
    checkModel("b", mb, SMALL_W, int'(b_addr), int'(b_we), int'(b_lw), int'(b_row),
               int'(b_kv), int'(b_state), int'(b_ovf), int'(b_werr));
    kv_cnt_a += int'(a_kv);
    kv_cnt_b += int'(b_kv);
    we_cnt_a += int'(a_we);
    we_cnt_b += int'(b_we);
  endtask

  task automatic clear_counts();
    kv_cnt_a = 0;
    kv_cnt_b = 0;
    we_cnt_a = 0;
    we_cnt_b = 0;
  endtask

  task automatic vs_pulse(input int high, input int low);
    repeat (high) applyStimulus(1, 0, 0, 1);
    repeat (low) applyStimulus(1, 0, 0, 0);
  endtask

  task automatic send_line(input int w, input int gap);
    repeat (w) applyStimulus(1, 1, 0, 0);
    repeat (gap) applyStimulus(1, 0, 0, 0);
  endtask

  task automatic run_frame();
    int nl, w, g, hs_at, abort_line, abort_px, reset_line;
    vs_pulse($urandom_range(1, 4), $urandom_range(3, 6));
    nl = $urandom_range(3, 9);
    abort_line = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
    reset_line = ($urandom_range(0, 15) == 0) ? $urandom_range(0, nl - 1) : -1;
    for (int l = 0; l < nl; l++) begin
      case ($urandom_range(0, 2))
        0:       w = 16;
        1:       w = $urandom_range(1, 12);
        default: w = $urandom_range(6, 24);
      endcase
      abort_px = $urandom_range(0, w - 1);
      for (int p = 0; p < w; p++) begin
        if (l == abort_line && p == abort_px) begin
          applyStimulus(1, 1, 0, 1);
          return;
        end
        if (l == reset_line && p == w / 2) begin
          applyStimulus(0, 1, 0, 0);
          applyStimulus(0, 1, 0, 0);
        end
        applyStimulus(1, 1, ($urandom_range(0, 40) == 0), 0);
      end
      g = $urandom_range(1, 8);
      hs_at = $urandom_range(0, g);
      for (int k = 0; k < g; k++) applyStimulus(1, 0, (k == hs_at), 0);
    end
  endtask

  initial begin
    ma = model_reset();
    mb = model_reset();
    clear_counts();

    // Reset held with dv toggling, then dv pulses while unsynchronised.
    for (int i = 0; i < 3; i++) applyStimulus(0, i[0], 0, 0);
    checkOutput("reset.state", int'(a_state), 0);
    checkOutput("reset.row_cnt", int'(a_row), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, i[0], 0, 0);
    checkOutput("idle.buf_we", we_cnt_a, 0);

    // Reference frame: 6 lines of 16 pixels, 8 blank cycles between lines.
    vs_pulse(3, 4);
    clear_counts();
    for (int l = 0; l < 6; l++) send_line(16, 8);
    checkOutput("frame.kv_cycles_a", kv_cnt_a, 24);
    checkOutput("frame.kv_cycles_b", kv_cnt_b, 8);
    checkOutput("frame.we_cycles_a", we_cnt_a, 96);
    checkOutput("frame.we_cycles_b", we_cnt_b, 48);
    checkOutput("frame.row_cnt", int'(a_row), 6);
    checkOutput("frame.line_width_a", int'(a_lw), 16);
    checkOutput("frame.line_width_b", int'(b_lw), 8);
    checkOutput("frame.overflow_b", int'(b_ovf), 1);
    checkOutput("frame.overflow_a", int'(a_ovf), 0);
    checkOutput("frame.state", int'(a_state), 3);

    // Vsync arrives at column 7 of the sixth line.
    vs_pulse(2, 4);
    for (int l = 0; l < 5; l++) send_line(16, 8);
    repeat (7) applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 1);
    checkOutput("midvs.buf_addr", int'(a_addr), 7);
    checkOutput("midvs.kernel_valid", int'(a_kv), 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("midvs.state", int'(a_state), 1);
    checkOutput("midvs.row_cnt", int'(a_row), 0);
    checkOutput("midvs.overflow_b", int'(b_ovf), 0);

    // Line widths 16,16,15,16,16: the width check (when built in) blocks the window.
    vs_pulse(1, 4);
    checkOutput("refill.state", int'(a_state), 2);
    clear_counts();
    send_line(16, 6);
    send_line(16, 6);
    send_line(15, 6);
    send_line(16, 6);
    send_line(16, 6);
`ifdef WIDTH_CHECK_EN
    checkOutput("width.err", int'(a_werr), 1);
    checkOutput("width.kv_cycles", kv_cnt_a, 0);
`else
    checkOutput("width.kv_cycles", kv_cnt_a, 12);
`endif

    for (int f = 0; f < 30; f++) run_frame();
    vs_pulse(2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
